// File: rtl/dmem_arbiter.sv
// Arbiter for the single data-memory/IO port, shared by the CPU MEM stage and a DMA/debug master.
// CPU has fixed priority; DMA is forced through after MAX_CPU_RUN contested CPU wins.
module dmem_arbiter #(
    parameter int RD_LAT      = 1,
    parameter int MAX_CPU_RUN = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic        cpu_stall,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,

    output logic [31:0] rdata,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_datain,
    output logic        mem_we,
    input  logic [31:0] mem_dataout
);

    localparam int               RUN_W    = $clog2(MAX_CPU_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_CPU_RUN);
    localparam logic [2:0]       LAT_LAST = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_e;

    state_e           state, state_nxt;
    logic             owner, owner_nxt;     // 0 = CPU, 1 = DMA
    logic [31:0]      addr_q, addr_nxt;
    logic [31:0]      wdata_q, wdata_nxt;
    logic             we_q, we_nxt;
    logic [2:0]       lat_cnt, lat_nxt;
    logic [RUN_W-1:0] run_cnt, run_nxt;
    logic             dma_wins;

    // The latched request drives the port at all times, so the address stays stable through WAIT.
    assign mem_addr   = addr_q;
    assign mem_datain = wdata_q;

    // A read grant does not release the pipeline; only its data beat does.
    assign cpu_stall = cpu_req & ~((cpu_gnt & we_q) | cpu_rvalid);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        addr_nxt   = addr_q;
        wdata_nxt  = wdata_q;
        we_nxt     = we_q;
        lat_nxt    = lat_cnt;
        run_nxt    = run_cnt;
        dma_wins   = 1'b0;
        cpu_gnt    = 1'b0;
        dma_gnt    = 1'b0;
        cpu_rvalid = 1'b0;
        dma_rvalid = 1'b0;
        mem_we     = 1'b0;
        rdata      = '0;

        unique case (state)
            IDLE: begin
                if (!dma_req) begin
                    run_nxt = '0;
                end
                if (cpu_req || dma_req) begin
                    dma_wins  = dma_req && (!cpu_req || run_cnt == RUN_MAX);
                    owner_nxt = dma_wins;
                    state_nxt = ISSUE;
                    if (dma_wins) begin
                        addr_nxt  = dma_addr;
                        wdata_nxt = dma_wdata;
                        we_nxt    = dma_we;
                        run_nxt   = '0;
                    end else begin
                        addr_nxt  = cpu_addr;
                        wdata_nxt = cpu_wdata;
                        we_nxt    = cpu_we;
                        if (dma_req && run_cnt != RUN_MAX) begin
                            run_nxt = run_cnt + 1'b1;
                        end
                    end
                end
            end

            ISSUE: begin
                mem_we    = we_q;
                cpu_gnt   = ~owner;
                dma_gnt   = owner;
                lat_nxt   = '0;
                state_nxt = we_q ? IDLE : WAIT;
            end

            WAIT: begin
                lat_nxt = lat_cnt + 3'd1;
                if (lat_cnt == LAT_LAST) begin
                    rdata      = mem_dataout;
                    cpu_rvalid = ~owner;
                    dma_rvalid = owner;
                    state_nxt  = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            lat_cnt <= '0;
            run_cnt <= '0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            we_q    <= we_nxt;
            lat_cnt <= lat_nxt;
            run_cnt <= run_nxt;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, randomized run against a transaction-timeline model,
// starvation check, and RD_LAT=3 corner sequences (dropped request, reset during WAIT).
module tb_dmem_arbiter;

    localparam int          RDL      = 1;
    localparam int          MAXR     = 4;
    localparam logic [31:0] IN_PORT0 = 32'h0000_005A;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- main instance (RD_LAT=1) ----------------
    logic        reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [31:0] dma_addr, dma_wdata;
    logic [31:0] rdata, mem_addr, mem_datain, mem_dataout;
    logic        mem_we;

    dmem_arbiter #(.RD_LAT(RDL), .MAX_CPU_RUN(MAXR)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .rdata(rdata), .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_we(mem_we),
        .mem_dataout(mem_dataout)
    );

    // datamem: 32-word RAM with one registered read stage; addr[7] selects the input port.
    logic [31:0] ram [32] = '{default: '0};
    logic [31:0] rd_q = '0;
    always @(posedge clock) begin
        if (mem_we && !mem_addr[7]) ram[mem_addr[6:2]] <= mem_datain;
        rd_q <= mem_addr[7] ? IN_PORT0 : ram[mem_addr[6:2]];
    end
    assign mem_dataout = rd_q;

    // ---------------- second instance (RD_LAT=3) ----------------
    logic        reset3;
    logic        c3_req, c3_we, c3_gnt, c3_rvalid, c3_stall;
    logic [31:0] c3_addr, c3_wdata;
    logic        d3_req, d3_we, d3_gnt, d3_rvalid;
    logic [31:0] d3_addr, d3_wdata;
    logic [31:0] rdata3, mem3_addr, mem3_datain, mem3_dataout;
    logic        mem3_we;

    dmem_arbiter #(.RD_LAT(3), .MAX_CPU_RUN(MAXR)) dut3 (
        .clock(clock), .reset(reset3),
        .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
        .cpu_gnt(c3_gnt), .cpu_rvalid(c3_rvalid), .cpu_stall(c3_stall),
        .dma_req(d3_req), .dma_we(d3_we), .dma_addr(d3_addr), .dma_wdata(d3_wdata),
        .dma_gnt(d3_gnt), .dma_rvalid(d3_rvalid),
        .rdata(rdata3), .mem_addr(mem3_addr), .mem_datain(mem3_datain), .mem_we(mem3_we),
        .mem_dataout(mem3_dataout)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], 16'hC3A5};
    endfunction

    // Three-stage read pipe: data for the address seen at the ISSUE edge appears three edges later.
    logic [31:0] p3 [3] = '{default: '0};
    always @(posedge clock) begin
        p3[0] <= pat(mem3_addr);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem3_dataout = p3[2];

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] act_main();
        return {58'b0, cpu_gnt, cpu_rvalid, cpu_stall, dma_gnt, dma_rvalid, mem_we,
                mem_addr, mem_datain, rdata};
    endfunction

    function automatic logic [159:0] act3();
        return {58'b0, c3_gnt, c3_rvalid, c3_stall, d3_gnt, d3_rvalid, mem3_we,
                mem3_addr, mem3_datain, rdata3};
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 32'h80;
        return {25'b0, 5'($urandom_range(0, 31)), 2'b00};
    endfunction

    task automatic reset_main();
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_main", act_main(), 160'b0);
    endtask

    task automatic reset_three();
        reset3 = 1'b1;
        c3_req = 1'b0; c3_we = 1'b0; c3_addr = '0; c3_wdata = '0;
        d3_req = 1'b0; d3_we = 1'b0; d3_addr = '0; d3_wdata = '0;
        repeat (2) @(posedge clock);
        #1 reset3 = 1'b0;
        @(negedge clock);
        check("reset_three", act3(), 160'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        c_req;
        logic        c_we;
        logic [31:0] c_addr;
        logic [31:0] c_wdata;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [5:0]  flags;   // {cpu_gnt, cpu_rvalid, cpu_stall, dma_gnt, dma_rvalid, mem_we}
        logic [31:0] m_addr;
        logic [31:0] m_din;
        logic [31:0] rd;
    } vec_t;

    vec_t vt [9];

    task automatic run_table();
        vt[0] = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 6'b001000, 32'h0,  32'h0,        32'h0};
        vt[1] = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 6'b100001, 32'h10, 32'hDEADBEEF, 32'h0};
        vt[2] = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0, 6'b001000, 32'h10, 32'hDEADBEEF, 32'h0};
        vt[3] = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0, 6'b101000, 32'h10, 32'h0,        32'h0};
        vt[4] = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0, 6'b010000, 32'h10, 32'h0,        32'hDEADBEEF};
        vt[5] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h80, 6'b000000, 32'h10, 32'h0,       32'h0};
        vt[6] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h80, 6'b000100, 32'h80, 32'h0,       32'h0};
        vt[7] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h80, 6'b000010, 32'h80, 32'h0,       IN_PORT0};
        vt[8] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  6'b000000, 32'h80, 32'h0,       32'h0};
        for (int i = 0; i < 9; i++) begin
            @(posedge clock);
            #1;
            cpu_req = vt[i].c_req; cpu_we = vt[i].c_we;
            cpu_addr = vt[i].c_addr; cpu_wdata = vt[i].c_wdata;
            dma_req = vt[i].d_req; dma_we = vt[i].d_we;
            dma_addr = vt[i].d_addr; dma_wdata = '0;
            @(negedge clock);
            check($sformatf("vec%0d", i), act_main(),
                  {58'b0, vt[i].flags, vt[i].m_addr, vt[i].m_din, vt[i].rd});
        end
    endtask

    // ---------------- randomized run vs. timeline model ----------------
    logic [31:0] m_ram [32];

    task automatic run_random(input int ncyc);
        int          idle_from, issue_c, rv_c, run;
        logic        t_dma, t_we, c_done, d_done;
        logic        e_cg, e_cr, e_cs, e_dg, e_dr, e_we;
        logic [31:0] lat_addr, lat_wdata, t_data, e_rd;

        foreach (m_ram[i]) m_ram[i] = '0;
        m_ram[4] = 32'hDEADBEEF;   // left in datamem by the vector table
        idle_from = 1; issue_c = -1; rv_c = -1; run = 0;
        t_dma = 1'b0; t_we = 1'b0; c_done = 1'b0; d_done = 1'b0;
        lat_addr = '0; lat_wdata = '0; t_data = '0;

        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clock);
            #1;
            if (!cpu_req || c_done) begin
                cpu_req   = ($urandom_range(0, 2) != 0);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = rand_addr();
                cpu_wdata = $urandom();
            end
            if (!dma_req || d_done) begin
                dma_req   = ($urandom_range(0, 2) != 0);
                dma_we    = 1'($urandom_range(0, 1));
                dma_addr  = rand_addr();
                dma_wdata = $urandom();
            end
            @(negedge clock);

            e_cg   = (c == issue_c) && !t_dma;
            e_dg   = (c == issue_c) && t_dma;
            e_we   = (c == issue_c) && t_we;
            e_cr   = (c == rv_c) && !t_dma;
            e_dr   = (c == rv_c) && t_dma;
            e_rd   = (c == rv_c) ? t_data : 32'h0;
            c_done = (e_cg && t_we) || e_cr;
            d_done = (e_dg && t_we) || e_dr;
            e_cs   = cpu_req && !c_done;
            check($sformatf("rand_c%0d", c), act_main(),
                  {58'b0, e_cg, e_cr, e_cs, e_dg, e_dr, e_we, lat_addr, lat_wdata, e_rd});

            // Arbitration at the end of an idle cycle schedules the whole transaction timeline.
            if (c >= idle_from) begin
                if (!dma_req) run = 0;
                if (cpu_req || dma_req) begin
                    t_dma = dma_req && (!cpu_req || run == MAXR);
                    if (t_dma) run = 0;
                    else if (dma_req && run < MAXR) run = run + 1;
                    t_we      = t_dma ? dma_we : cpu_we;
                    lat_addr  = t_dma ? dma_addr : cpu_addr;
                    lat_wdata = t_dma ? dma_wdata : cpu_wdata;
                    issue_c   = c + 1;
                    if (t_we) begin
                        if (!lat_addr[7]) m_ram[lat_addr[6:2]] = lat_wdata;
                        rv_c      = -1;
                        idle_from = c + 2;
                    end else begin
                        t_data    = lat_addr[7] ? IN_PORT0 : m_ram[lat_addr[6:2]];
                        rv_c      = c + 1 + RDL;
                        idle_from = c + 2 + RDL;
                    end
                end
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        reset3 = 1'b1;
        c3_req = 1'b0; c3_we = 1'b0; c3_addr = '0; c3_wdata = '0;
        d3_req = 1'b0; d3_we = 1'b0; d3_addr = '0; d3_wdata = '0;

        reset_main();
        run_table();

        reset_main();
        run_random(500);

        // Both masters write back-to-back into IO space: grants must repeat CPU x MAXR, then DMA.
        reset_main();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'h1111_0000;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h84; dma_wdata = 32'h2222_0000;
        n = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            if (cpu_gnt || dma_gnt) begin
                check($sformatf("starve_gnt%0d", n), {158'b0, cpu_gnt, dma_gnt},
                      (n % (MAXR + 1) == MAXR) ? 160'b01 : 160'b10);
                n++;
            end
        end
        check("starve_count", 160'(n), 160'd15);
        cpu_req = 1'b0; dma_req = 1'b0;

        // RD_LAT=3 read with the request dropped right after it is latched.
        reset_three();
        for (int c = 1; c <= 7; c++) begin
            @(posedge clock);
            #1;
            c3_req = (c == 1); c3_we = 1'b0; c3_addr = 32'h20;
            @(negedge clock);
            check($sformatf("drop_c%0d", c), act3(),
                  {58'b0, c == 2, c == 5, c == 1, 3'b000,
                   (c >= 2) ? 32'h20 : 32'h0, 32'h0, (c == 5) ? pat(32'h20) : 32'h0});
        end

        // Reset arriving during WAIT aborts the read: no rvalid, everything back to zero.
        reset_three();
        for (int c = 1; c <= 7; c++) begin
            @(posedge clock);
            #1;
            c3_req = (c <= 3); c3_we = 1'b0; c3_addr = 32'h24;
            reset3 = (c == 3);
            @(negedge clock);
            check($sformatf("rstwait_c%0d", c), act3(),
                  {58'b0, c == 2, 1'b0, c <= 3, 3'b000,
                   (c == 2 || c == 3) ? 32'h24 : 32'h0, 32'h0, 32'h0});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
